mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Memory-to-writeback pipeline stage that feeds the register file write port.
- Captures the EX/MEM result and, for loads, waits for the data-memory response, then aligns and sign/zero-extends it.
- Presents a one-cycle write (address, data, enable, IRQ bank select).
- Asserts MEM_WB_Freeze to stall upstream and suppress register-file writes while a load is outstanding.

Parameters:
- LOAD_TIMEOUT, 16, max cycles to wait for DMEM_Rvalid before abandoning the load (≥2).
- TMO_W, 5, width of timeout counter; must satisfy 2^TMO_W > LOAD_TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- EX_Valid  in  1  EX/MEM holds an instruction this cycle
- EX_Reg_Write  in  1  instruction writes rd
- EX_Is_Load  in  1  instruction is a load
- EX_Funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- EX_Addr_Lo  in  2  byte offset of load address
- EX_RD_Addr  in  5  destination register
- EX_Result  in  32  ALU result (non-load write data)
- EX_IRQ  in  1  instruction executes in IRQ context (shadow bank)
- DMEM_Rdata  in  32  load read data, word-aligned
- DMEM_Rvalid  in  1  read data valid, single-cycle pulse
- RD_Write_Addr  out  5  register file write address
- RD_Write_Data  out  32  register file write data
- Reg_Write_Enable__EX_MEM  out  1  write strobe, one cycle per retired instruction
- WB_Ctrl__IRQ  out  1  selects shadow bank for the write
- MEM_WB_Freeze  out  1  stage busy; upstream must hold, register file must ignore writes
- Load_Fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (async, RST_N=0): state IDLE; all outputs 0; timeout counter 0. Deassertion is synchronised by the owner of RST_N.
- Stage state machine: IDLE, WAIT_LOAD.
- IDLE, EX_Valid=1, EX_Is_Load=0:
  - Register EX_RD_Addr, EX_Result and EX_IRQ.
  - Next cycle, drive Reg_Write_Enable__EX_MEM = EX_Reg_Write & (EX_RD_Addr≠0). Latency 1.
- IDLE, EX_Valid=1, EX_Is_Load=1, legal and aligned:
  - Latch rd, funct3, Addr_Lo and IRQ; go to WAIT_LOAD.
  - Clear the counter.
  - Drive MEM_WB_Freeze=1 from the next cycle.
- Alignment rules:
  - LH/LHU with Addr_Lo[0]=1 is misaligned.
  - LW with Addr_Lo≠0 is misaligned.
  - funct3 in {011, 110, 111} is illegal.
  - Misaligned or illegal: no state change, no write, Load_Fault pulses next cycle.
- WAIT_LOAD:
  - MEM_WB_Freeze=1 and Reg_Write_Enable__EX_MEM=0.
  - EX_* inputs are ignored.
  - The counter increments each cycle.
- WAIT_LOAD, DMEM_Rvalid=1:
  - Extract the byte or halfword at Addr_Lo (byte lane Addr_Lo, halfword lane Addr_Lo[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Register the result; return to IDLE.
  - MEM_WB_Freeze=0 and the write strobe is high in the next cycle. Load latency = Rvalid cycle + 1.
- WAIT_LOAD, counter reaches LOAD_TIMEOUT without Rvalid:
  - Return to IDLE; Load_Fault pulses; no write.
  - A later stray DMEM_Rvalid in IDLE is ignored.
- Rvalid and timeout in the same cycle: Rvalid wins, no fault.
- Write strobe lasts exactly one cycle; RD_Write_Addr, RD_Write_Data and WB_Ctrl__IRQ are valid while it is high and hold their last value otherwise.
- Back-to-back non-loads: one write per cycle, no bubbles.
- A load arriving in the cycle after a non-load write is accepted normally.
- Reset mid-WAIT_LOAD: immediate return to IDLE, freeze drops, pending load discarded.

Test Plan:
- ALU op EX_RD_Addr=5, EX_Result=0xDEADBEEF, EX_Reg_Write=1, EX_IRQ=0 -> next cycle: strobe=1, addr=5, data=0xDEADBEEF, IRQ=0; strobe low the cycle after.
- EX_RD_Addr=0, EX_Reg_Write=1 -> no write strobe.
- LB, Addr_Lo=2, DMEM_Rdata=0x1280FF34, Rvalid 3 cycles later -> freeze high 3 cycles, then write data=0xFFFFFF80.
- Same load as LBU -> data=0x00000080.
- LHU, Addr_Lo=2, Rdata=0x9ABC1234 -> data=0x00009ABC.
- LW with Addr_Lo=1 -> Load_Fault pulse, no freeze, no write.
- Load with no Rvalid -> freeze held 16 cycles, Load_Fault pulse, no write; a subsequent Rvalid in IDLE produces no write.
- Load with EX_IRQ=1, rd=3, Rvalid 1 cycle later -> write with WB_Ctrl__IRQ=1, addr=3.
- RST_N low during WAIT_LOAD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB stage driving the register-file write port.
// Non-loads retire next cycle; loads wait for DMEM_Rvalid, then align/extend.
module mem_wb_writeback #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int TMO_W        = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EX_Valid,
    input  logic        EX_Reg_Write,
    input  logic        EX_Is_Load,
    input  logic [2:0]  EX_Funct3,
    input  logic [1:0]  EX_Addr_Lo,
    input  logic [4:0]  EX_RD_Addr,
    input  logic [31:0] EX_Result,
    input  logic        EX_IRQ,
    input  logic [31:0] DMEM_Rdata,
    input  logic        DMEM_Rvalid,
    output logic [4:0]  RD_Write_Addr,
    output logic [31:0] RD_Write_Data,
    output logic        Reg_Write_Enable__EX_MEM,
    output logic        WB_Ctrl__IRQ,
    output logic        MEM_WB_Freeze,
    output logic        Load_Fault
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic [4:0]       ld_rd, ld_rd_nxt;
    logic [2:0]       ld_f3, ld_f3_nxt;
    logic [1:0]       ld_lo, ld_lo_nxt;
    logic             ld_irq, ld_irq_nxt;
    logic             ld_we, ld_we_nxt;
    logic [4:0]       addr_nxt;
    logic [31:0]      data_nxt;
    logic             we_nxt, irq_nxt, fault_nxt;
    logic             ld_bad, rd_we;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_data;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

    assign MEM_WB_Freeze = (state == WAIT_LOAD);
    assign rd_we         = EX_Reg_Write && (EX_RD_Addr != 5'd0);

    always_comb begin
        ld_bad = 1'b0;
        unique case (EX_Funct3)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = EX_Addr_Lo[0];
            3'b010:         ld_bad = |EX_Addr_Lo;
            default:        ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_b = DMEM_Rdata[7:0];
        unique case (ld_lo)
            2'd0: ld_b = DMEM_Rdata[7:0];
            2'd1: ld_b = DMEM_Rdata[15:8];
            2'd2: ld_b = DMEM_Rdata[23:16];
            2'd3: ld_b = DMEM_Rdata[31:24];
        endcase
        ld_h = ld_lo[1] ? DMEM_Rdata[31:16] : DMEM_Rdata[15:0];
        ld_data = DMEM_Rdata;
        unique case (ld_f3)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_data = {24'd0, ld_b};
            3'b101:  ld_data = {16'd0, ld_h};
            default: ld_data = DMEM_Rdata;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ld_rd_nxt  = ld_rd;
        ld_f3_nxt  = ld_f3;
        ld_lo_nxt  = ld_lo;
        ld_irq_nxt = ld_irq;
        ld_we_nxt  = ld_we;
        addr_nxt   = RD_Write_Addr;
        data_nxt   = RD_Write_Data;
        irq_nxt    = WB_Ctrl__IRQ;
        we_nxt     = 1'b0;
        fault_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (EX_Valid && !EX_Is_Load) begin
                    if (rd_we) begin
                        we_nxt   = 1'b1;
                        addr_nxt = EX_RD_Addr;
                        data_nxt = EX_Result;
                        irq_nxt  = EX_IRQ;
                    end
                end else if (EX_Valid && ld_bad) begin
                    fault_nxt = 1'b1;
                end else if (EX_Valid) begin
                    state_nxt  = WAIT_LOAD;
                    cnt_nxt    = '0;
                    ld_rd_nxt  = EX_RD_Addr;
                    ld_f3_nxt  = EX_Funct3;
                    ld_lo_nxt  = EX_Addr_Lo;
                    ld_irq_nxt = EX_IRQ;
                    ld_we_nxt  = rd_we;
                end
            end
            WAIT_LOAD: begin
                cnt_nxt = cnt + 1'b1;
                // Rvalid takes priority over an expiring timeout
                if (DMEM_Rvalid) begin
                    state_nxt = IDLE;
                    if (ld_we) begin
                        we_nxt   = 1'b1;
                        addr_nxt = ld_rd;
                        data_nxt = ld_data;
                        irq_nxt  = ld_irq;
                    end
                end else if (cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state                    <= IDLE;
            cnt                      <= '0;
            ld_rd                    <= '0;
            ld_f3                    <= '0;
            ld_lo                    <= '0;
            ld_irq                   <= 1'b0;
            ld_we                    <= 1'b0;
            RD_Write_Addr            <= '0;
            RD_Write_Data            <= '0;
            WB_Ctrl__IRQ             <= 1'b0;
            Reg_Write_Enable__EX_MEM <= 1'b0;
            Load_Fault               <= 1'b0;
        end else begin
            state                    <= state_nxt;
            cnt                      <= cnt_nxt;
            ld_rd                    <= ld_rd_nxt;
            ld_f3                    <= ld_f3_nxt;
            ld_lo                    <= ld_lo_nxt;
            ld_irq                   <= ld_irq_nxt;
            ld_we                    <= ld_we_nxt;
            RD_Write_Addr            <= addr_nxt;
            RD_Write_Data            <= data_nxt;
            WB_Ctrl__IRQ             <= irq_nxt;
            Reg_Write_Enable__EX_MEM <= we_nxt;
            Load_Fault               <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vector table, hand sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_wb_writeback;

    localparam int LOAD_TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EX_Valid, EX_Reg_Write, EX_Is_Load, EX_IRQ;
    logic [2:0]  EX_Funct3;
    logic [1:0]  EX_Addr_Lo;
    logic [4:0]  EX_RD_Addr;
    logic [31:0] EX_Result, DMEM_Rdata;
    logic        DMEM_Rvalid;
    logic [4:0]  RD_Write_Addr;
    logic [31:0] RD_Write_Data;
    logic        Reg_Write_Enable__EX_MEM, WB_Ctrl__IRQ;
    logic        MEM_WB_Freeze, Load_Fault;

    int checks = 0;
    int failures = 0;

    mem_wb_writeback #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .TMO_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .EX_Valid(EX_Valid), .EX_Reg_Write(EX_Reg_Write),
        .EX_Is_Load(EX_Is_Load), .EX_Funct3(EX_Funct3),
        .EX_Addr_Lo(EX_Addr_Lo), .EX_RD_Addr(EX_RD_Addr),
        .EX_Result(EX_Result), .EX_IRQ(EX_IRQ),
        .DMEM_Rdata(DMEM_Rdata), .DMEM_Rvalid(DMEM_Rvalid),
        .RD_Write_Addr(RD_Write_Addr), .RD_Write_Data(RD_Write_Data),
        .Reg_Write_Enable__EX_MEM(Reg_Write_Enable__EX_MEM),
        .WB_Ctrl__IRQ(WB_Ctrl__IRQ), .MEM_WB_Freeze(MEM_WB_Freeze),
        .Load_Fault(Load_Fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        ld;
        logic        rw;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        irq;
        logic [31:0] rdata;
        int          dly;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_irq;
        logic        e_fault;
        int          e_frz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic ld, input logic rw,
                       input logic [2:0] f3, input logic [1:0] lo,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic irq, input logic [31:0] rdata,
                       input int dly, input logic e_we,
                       input logic [31:0] e_data, input logic e_fault,
                       input int e_frz);
        vec_t v;
        v.name = nm; v.ld = ld; v.rw = rw; v.f3 = f3; v.lo = lo;
        v.rd = rd; v.res = res; v.irq = irq; v.rdata = rdata;
        v.dly = dly; v.e_we = e_we; v.e_addr = rd; v.e_data = e_data;
        v.e_irq = irq; v.e_fault = e_fault; v.e_frz = e_frz;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        EX_Valid = 1'b0; EX_Reg_Write = 1'b0; EX_Is_Load = 1'b0;
        EX_Funct3 = 3'd0; EX_Addr_Lo = 2'd0; EX_RD_Addr = 5'd0;
        EX_Result = 32'd0; EX_IRQ = 1'b0;
        DMEM_Rdata = 32'd0; DMEM_Rvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        EX_Valid = 1'b1; EX_Reg_Write = v.rw; EX_Is_Load = v.ld;
        EX_Funct3 = v.f3; EX_Addr_Lo = v.lo; EX_RD_Addr = v.rd;
        EX_Result = v.res; EX_IRQ = v.irq;
        tick();
        EX_Valid = 1'b0;
        for (int k = 1; k <= v.e_frz; k++) begin
            chk({v.name, " freeze"}, 32'(MEM_WB_Freeze), 32'd1);
            chk({v.name, " we in wait"},
                32'(Reg_Write_Enable__EX_MEM), 32'd0);
            if (k == v.dly) begin
                DMEM_Rvalid = 1'b1;
                DMEM_Rdata  = v.rdata;
            end
            tick();
            DMEM_Rvalid = 1'b0;
        end
        chk({v.name, " we"}, 32'(Reg_Write_Enable__EX_MEM), 32'(v.e_we));
        chk({v.name, " fault"}, 32'(Load_Fault), 32'(v.e_fault));
        chk({v.name, " freeze off"}, 32'(MEM_WB_Freeze), 32'd0);
        if (v.e_we) begin
            chk({v.name, " addr"}, 32'(RD_Write_Addr), 32'(v.e_addr));
            chk({v.name, " data"}, RD_Write_Data, v.e_data);
            chk({v.name, " irq"}, 32'(WB_Ctrl__IRQ), 32'(v.e_irq));
        end
        tick();
        chk({v.name, " we one-shot"},
            32'(Reg_Write_Enable__EX_MEM), 32'd0);
        chk({v.name, " fault one-shot"}, 32'(Load_Fault), 32'd0);
    endtask

    // Reference model: works from load size and byte offset arithmetic
    function automatic bit legal(input logic [2:0] f3, input logic [1:0] lo);
        int sz;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        sz = 1 << f3[1:0];
        return (int'(lo) % sz) == 0;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] f3,
                                        input logic [1:0] lo,
                                        input logic [31:0] d);
        int     sz;
        longint v;
        sz = 1 << f3[1:0];
        v = (longint'(d) >> (8 * int'(lo))) & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    bit          m_busy;
    int          m_waited;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic        m_irq, m_we;
    logic        e_we, e_fault, e_irq;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    task automatic model_step();
        e_we = 1'b0;
        e_fault = 1'b0;
        if (!m_busy) begin
            if (EX_Valid && !EX_Is_Load) begin
                if (EX_Reg_Write && EX_RD_Addr != 5'd0) begin
                    e_we = 1'b1; e_addr = EX_RD_Addr;
                    e_data = EX_Result; e_irq = EX_IRQ;
                end
            end else if (EX_Valid && !legal(EX_Funct3, EX_Addr_Lo)) begin
                e_fault = 1'b1;
            end else if (EX_Valid) begin
                m_busy = 1'b1; m_waited = 0;
                m_rd = EX_RD_Addr; m_f3 = EX_Funct3; m_lo = EX_Addr_Lo;
                m_irq = EX_IRQ;
                m_we = EX_Reg_Write && EX_RD_Addr != 5'd0;
            end
        end else begin
            m_waited++;
            if (DMEM_Rvalid) begin
                m_busy = 1'b0;
                if (m_we) begin
                    e_we = 1'b1; e_addr = m_rd;
                    e_data = ext(m_f3, m_lo, DMEM_Rdata); e_irq = m_irq;
                end
            end else if (m_waited == LOAD_TIMEOUT) begin
                m_busy = 1'b0;
                e_fault = 1'b1;
            end
        end
    endtask

    initial begin
        idle_inputs();
        RST_N = 1'b0;
        #1;
        chk("reset we", 32'(Reg_Write_Enable__EX_MEM), 32'd0);
        chk("reset freeze", 32'(MEM_WB_Freeze), 32'd0);
        chk("reset fault", 32'(Load_Fault), 32'd0);
        chk("reset addr", 32'(RD_Write_Addr), 32'd0);
        chk("reset data", RD_Write_Data, 32'd0);
        chk("reset irq", 32'(WB_Ctrl__IRQ), 32'd0);
        #11;
        RST_N = 1'b1;
        tick();

        //   name        ld rw f3  lo rd  res           irq rdata        dly we exp_data      flt frz
        add("alu",       0, 1, 0, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0,  1, 32'hDEADBEEF, 0, 0);
        add("alu x0",    0, 1, 0, 0, 0,  32'h12345678, 0, 32'h0,        0,  0, 32'h0,        0, 0);
        add("alu nowr",  0, 0, 0, 0, 7,  32'h0000AAAA, 1, 32'h0,        0,  0, 32'h0,        0, 0);
        add("alu irq",   0, 1, 0, 0, 31, 32'h0F0F0F0F, 1, 32'h0,        0,  1, 32'h0F0F0F0F, 0, 0);
        add("lb",        1, 1, 0, 2, 4,  32'h0,        0, 32'h1280FF34, 3,  1, 32'hFFFFFF80, 0, 3);
        add("lbu",       1, 1, 4, 2, 4,  32'h0,        0, 32'h1280FF34, 3,  1, 32'h00000080, 0, 3);
        add("lhu",       1, 1, 5, 2, 6,  32'h0,        0, 32'h9ABC1234, 1,  1, 32'h00009ABC, 0, 1);
        add("lh",        1, 1, 1, 0, 8,  32'h0,        0, 32'h9ABC8234, 2,  1, 32'hFFFF8234, 0, 2);
        add("lb pos",    1, 1, 0, 3, 9,  32'h0,        0, 32'h7F000000, 2,  1, 32'h0000007F, 0, 2);
        add("lw",        1, 1, 2, 0, 10, 32'h0,        0, 32'h12345678, 1,  1, 32'h12345678, 0, 1);
        add("lw irq",    1, 1, 2, 0, 3,  32'h0,        1, 32'hCAFEF00D, 1,  1, 32'hCAFEF00D, 0, 1);
        add("lw mis",    1, 1, 2, 1, 11, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 0);
        add("lh mis",    1, 1, 1, 1, 11, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 0);
        add("f3 011",    1, 1, 3, 0, 11, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 0);
        add("f3 110",    1, 1, 6, 0, 11, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 0);
        add("rv at tmo", 1, 1, 2, 0, 12, 32'h0,        0, 32'hA5A5A5A5, 16, 1, 32'hA5A5A5A5, 0, 16);
        add("timeout",   1, 1, 2, 0, 13, 32'h0,        0, 32'h0,        -1, 0, 32'h0,        1, 16);

        foreach (vq[i]) run_vec(vq[i]);

        DMEM_Rvalid = 1'b1;
        DMEM_Rdata  = 32'h55555555;
        tick();
        DMEM_Rvalid = 1'b0;
        chk("stray rvalid we", 32'(Reg_Write_Enable__EX_MEM), 32'd0);
        chk("stray rvalid freeze", 32'(MEM_WB_Freeze), 32'd0);

        // back-to-back ALU writes, then a load right behind them
        EX_Valid = 1'b1; EX_Reg_Write = 1'b1; EX_Is_Load = 1'b0;
        EX_RD_Addr = 5'd1; EX_Result = 32'h111; EX_IRQ = 1'b0;
        tick();
        chk("b2b 1 we", 32'(Reg_Write_Enable__EX_MEM), 32'd1);
        chk("b2b 1 data", RD_Write_Data, 32'h111);
        EX_RD_Addr = 5'd2; EX_Result = 32'h222;
        tick();
        chk("b2b 2 we", 32'(Reg_Write_Enable__EX_MEM), 32'd1);
        chk("b2b 2 addr", 32'(RD_Write_Addr), 32'd2);
        chk("b2b 2 data", RD_Write_Data, 32'h222);
        EX_Is_Load = 1'b1; EX_Funct3 = 3'b010; EX_Addr_Lo = 2'd0;
        EX_RD_Addr = 5'd20;
        tick();
        EX_Valid = 1'b0;
        chk("b2b ld freeze", 32'(MEM_WB_Freeze), 32'd1);
        chk("b2b ld we", 32'(Reg_Write_Enable__EX_MEM), 32'd0);
        DMEM_Rvalid = 1'b1; DMEM_Rdata = 32'h00C0FFEE;
        tick();
        DMEM_Rvalid = 1'b0;
        chk("b2b ld wr", 32'(Reg_Write_Enable__EX_MEM), 32'd1);
        chk("b2b ld addr", 32'(RD_Write_Addr), 32'd20);
        chk("b2b ld data", RD_Write_Data, 32'h00C0FFEE);

        // async reset while a load is pending
        EX_Valid = 1'b1; EX_Is_Load = 1'b1; EX_RD_Addr = 5'd21;
        tick();
        EX_Valid = 1'b0;
        tick();
        chk("pre-rst freeze", 32'(MEM_WB_Freeze), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid rst freeze", 32'(MEM_WB_Freeze), 32'd0);
        chk("mid rst addr", 32'(RD_Write_Addr), 32'd0);
        chk("mid rst data", RD_Write_Data, 32'd0);
        chk("mid rst we", 32'(Reg_Write_Enable__EX_MEM), 32'd0);
        #2;
        RST_N = 1'b1;
        DMEM_Rvalid = 1'b1; DMEM_Rdata = 32'hFFFFFFFF;
        tick();
        DMEM_Rvalid = 1'b0;
        chk("post rst we", 32'(Reg_Write_Enable__EX_MEM), 32'd0);
        chk("post rst freeze", 32'(MEM_WB_Freeze), 32'd0);

        // random traffic vs. model
        idle_inputs();
        tick();
        m_busy = 1'b0;
        m_waited = 0;
        for (int c = 0; c < 3000; c++) begin
            EX_Valid = ($urandom_range(0, 3) != 0);
            EX_Is_Load = $urandom_range(0, 1) == 1;
            EX_Reg_Write = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0)
                EX_Funct3 = 3'($urandom_range(0, 7));
            else
                case ($urandom_range(0, 4))
                    0: EX_Funct3 = 3'b000;
                    1: EX_Funct3 = 3'b001;
                    2: EX_Funct3 = 3'b010;
                    3: EX_Funct3 = 3'b100;
                    default: EX_Funct3 = 3'b101;
                endcase
            EX_Addr_Lo = 2'($urandom_range(0, 3));
            EX_RD_Addr = 5'($urandom_range(0, 31));
            EX_Result = $urandom;
            EX_IRQ = $urandom_range(0, 1) == 1;
            DMEM_Rdata = $urandom;
            if ((c / 150) % 3 == 2)
                DMEM_Rvalid = 1'b0;
            else
                DMEM_Rvalid = ($urandom_range(0, 3) == 0);
            model_step();
            tick();
            chk($sformatf("rnd%0d we", c),
                32'(Reg_Write_Enable__EX_MEM), 32'(e_we));
            chk($sformatf("rnd%0d fault", c), 32'(Load_Fault), 32'(e_fault));
            chk($sformatf("rnd%0d freeze", c),
                32'(MEM_WB_Freeze), 32'(m_busy));
            if (e_we) begin
                chk($sformatf("rnd%0d addr", c),
                    32'(RD_Write_Addr), 32'(e_addr));
                chk($sformatf("rnd%0d data", c), RD_Write_Data, e_data);
                chk($sformatf("rnd%0d irq", c),
                    32'(WB_Ctrl__IRQ), 32'(e_irq));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
